dot_matrix_capture: RTL and testbench

Receive-side monitor for the 8x8 RGB display link. It samples the serial shift-register signals that normally drive the 74HC595-based 8x8 module: SH_CP, ST_CP, DS, OE, the shift-register clear and the one-hot row select. From these it rebuilds the 192-bit frame exactly as the module would latch it. It sits beside, or in place of, the display so that frame contents can be mirrored, checked in self-test, or forwarded, with per-row error reporting.

---
 rtl/dot_matrix_capture.sv | 140 ++++++++++++++
 tb/tb_dot_matrix_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_matrix_capture.sv
// Receive-side monitor for the 8x8 RGB shift-register display link.
// Rebuilds the latched frame from SH_CP/ST_CP/DS/OE/CLR/row activity.
module dot_matrix_capture #(
  parameter int ROWS        = 8,
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    link_sh_cp,
  input  logic                    link_st_cp,
  input  logic                    link_ds,
  input  logic                    link_oe,
  input  logic                    link_clr_n,
  input  logic [ROWS-1:0]         link_row,
  output logic [ROWS*WIDTH-1:0]   frame,
  output logic                    row_we,
  output logic [2:0]              row_idx,
  output logic [WIDTH-1:0]        row_data,
  output logic                    frame_done,
  output logic                    err_count,
  output logic                    err_row
);

  // Edge-detected signals carry one extra flop after the synchronizer;
  // level signals (DS, clear, row) stop at the aligned stage.
  localparam int         D    = SYNC_STAGES + 2;
  localparam logic [2:0] LAST = 3'(ROWS - 1);
  localparam logic [4:0] FULL = 5'(WIDTH);

  logic [1:0]      rst_q;
  logic            en;
  logic [D-1:0]    sh_c, st_c, oe_c;
  logic [D-2:0]    ds_c, clr_c;
  logic [ROWS-1:0] row_c [D-1];

  logic             sh_rise, st_rise, oe_fall, clr, ds_s;
  logic [ROWS-1:0]  row_s;

  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] stor, stor_n;
  logic [4:0]       cnt, cnt_n;
  logic             cnt_ok, onehot;
  logic [2:0]       idx;

  // Release of reset is re-timed so edges right after it are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign en = rst_q[1];

  // Synchronizer chains, newest sample at index 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_c  <= '0;
      st_c  <= '0;
      oe_c  <= '0;
      ds_c  <= '0;
      clr_c <= '0;
      for (int i = 0; i < D-1; i++) row_c[i] <= '0;
    end else begin
      sh_c  <= {sh_c[D-2:0], link_sh_cp};
      st_c  <= {st_c[D-2:0], link_st_cp};
      oe_c  <= {oe_c[D-2:0], link_oe};
      ds_c  <= {ds_c[D-3:0], link_ds};
      clr_c <= {clr_c[D-3:0], link_clr_n};
      row_c[0] <= link_row;
      for (int i = 1; i < D-1; i++) row_c[i] <= row_c[i-1];
    end
  end

  assign sh_rise = en & sh_c[D-2] & ~sh_c[D-1];
  assign st_rise = en & st_c[D-2] & ~st_c[D-1];
  assign oe_fall = en & ~oe_c[D-2] & oe_c[D-1];
  assign clr     = en & ~clr_c[D-2];
  assign ds_s    = ds_c[D-2];
  assign row_s   = row_c[D-2];

  // Decode the one-hot row select.
  always_comb begin
    idx    = '0;
    onehot = $onehot(row_s);
    for (int i = 0; i < ROWS; i++)
      if (row_s[i]) idx = i[2:0];
  end

  // Same-cycle ordering: clear, shift, store, then commit.
  always_comb begin
    sr_n   = sr;
    cnt_n  = cnt;
    stor_n = stor;
    if (clr) begin
      sr_n  = '0;
      cnt_n = '0;
    end
    if (sh_rise) begin
      sr_n = {ds_s, sr_n[WIDTH-1:1]};
      if (cnt_n != 5'd31) cnt_n = cnt_n + 5'd1;
    end
    if (st_rise) stor_n = sr_n;
    cnt_ok = (cnt_n == FULL);
    if (oe_fall) cnt_n = '0;
  end

  // Datapath registers, commit and error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr         <= '0;
      stor       <= '0;
      cnt        <= '0;
      frame      <= '0;
      row_we     <= 1'b0;
      row_idx    <= '0;
      row_data   <= '0;
      frame_done <= 1'b0;
      err_count  <= 1'b0;
      err_row    <= 1'b0;
    end else begin
      sr         <= sr_n;
      stor       <= stor_n;
      cnt        <= cnt_n;
      row_we     <= 1'b0;
      frame_done <= 1'b0;
      if (oe_fall) begin
        if (!onehot) err_row   <= 1'b1;
        if (!cnt_ok) err_count <= 1'b1;
        if (onehot && cnt_ok) begin
          frame[int'(idx)*WIDTH +: WIDTH] <= stor;
          row_we     <= 1'b1;
          row_idx    <= idx;
          row_data   <= stor;
          frame_done <= (idx == LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_capture.sv
// Bench for dot_matrix_capture: directed table, randomized rows
// against a transaction-level frame model, and mid-row reset.
module tb_dot_matrix_capture;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sh = 1'b0, st = 1'b0, ds = 1'b0;
  logic         oe = 1'b1, clr_n = 1'b1;
  logic [7:0]   row = '0;
  logic [191:0] frame;
  logic         row_we, frame_done, err_count, err_row;
  logic [2:0]   row_idx;
  logic [23:0]  row_data;

  always #5 clk = ~clk;

  dot_matrix_capture dut (
    .clk(clk), .reset(reset),
    .link_sh_cp(sh), .link_st_cp(st), .link_ds(ds),
    .link_oe(oe), .link_clr_n(clr_n), .link_row(row),
    .frame(frame), .row_we(row_we), .row_idx(row_idx),
    .row_data(row_data), .frame_done(frame_done),
    .err_count(err_count), .err_row(err_row)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [191:0] act,
                     input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: bits sent since the last clear, count since
  // last clear/commit, stored word and the frame as an array.
  bit          m_q[$];
  int          m_cnt;
  logic [23:0] m_stor;
  logic [23:0] m_frame[8];
  bit          m_er, m_ec;

  function automatic logic [23:0] m_sr();
    logic [23:0] r = '0;
    for (int p = 0; p < 24; p++) begin
      int k = m_q.size() - 24 + p;
      if (k >= 0) r[p] = m_q[k];
    end
    return r;
  endfunction

  function automatic logic [191:0] m_frame_flat();
    logic [191:0] f;
    for (int r = 0; r < 8; r++) f[r*24 +: 24] = m_frame[r];
    return f;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_cnt = 0;
    m_stor = '0;
    m_er = 0;
    m_ec = 0;
    for (int r = 0; r < 8; r++) m_frame[r] = '0;
  endtask

  task automatic link_clear();
    clr_n = 1'b0; hold(3);
    clr_n = 1'b1; hold(3);
    m_q.delete();
    m_cnt = 0;
  endtask

  task automatic shift_bit(input bit b);
    ds = b; hold(2);
    sh = 1'b1; hold(3);
    sh = 1'b0; hold(2);
    m_q.push_back(b);
    if (m_cnt < 31) m_cnt++;
  endtask

  task automatic store();
    st = 1'b1; hold(3);
    st = 1'b0; hold(2);
    m_stor = m_sr();
  endtask

  typedef struct {
    int          we;
    int          lat;
    int          done;
    logic [2:0]  idx;
    logic [23:0] data;
  } obs_t;

  task automatic commit(input logic [7:0] sel, output obs_t o);
    o.we = 0; o.lat = -1; o.done = 0; o.idx = '0; o.data = '0;
    row = sel; hold(3);
    oe = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (row_we) begin
        o.we++;
        if (o.lat < 0) o.lat = c;
        o.idx = row_idx;
        o.data = row_data;
      end
      if (frame_done) o.done++;
    end
    oe = 1'b1; hold(3);
  endtask

  task automatic do_row(input logic [7:0] sel, input logic [23:0] data,
                        input int n, input bit st_each, output obs_t o);
    bit          p_ok;
    logic [2:0]  p_idx;
    logic [23:0] p_data;
    link_clear();
    for (int i = 0; i < n; i++) begin
      shift_bit(i < 24 ? data[i] : 1'($urandom));
      if (st_each) store();
    end
    if (!st_each) store();
    p_ok = $onehot(sel) && (m_cnt == 24);
    p_idx = '0;
    for (int r = 0; r < 8; r++) if (sel[r]) p_idx = 3'(r);
    p_data = m_stor;
    commit(sel, o);
    m_cnt = 0;
    if (!$onehot(sel)) m_er = 1;
    if (m_cnt_was_bad(p_ok, sel)) m_ec = 1;
    if (p_ok) m_frame[p_idx] = p_data;
    chk("row_we_pulses", o.we, p_ok);
    if (p_ok) begin
      chk("latency", o.lat, 4);
      chk("row_idx", o.idx, p_idx);
      chk("row_data", o.data, p_data);
    end
    chk("frame_done", o.done, (p_ok && p_idx == 3'd7));
    chk("err_row", err_row, m_er);
    chk("err_count", err_count, m_ec);
    chk("frame", frame, m_frame_flat());
  endtask

  // Count error applies whenever the shift count was not a full row,
  // independent of the row-select verdict.
  bit last_cnt_bad;
  function automatic bit m_cnt_was_bad(bit ok, logic [7:0] sel);
    return last_cnt_bad;
  endfunction

  typedef struct {
    logic [7:0]  sel;
    logic [23:0] data;
    int          n;
    bit          st_each;
    bit          we;
    logic [2:0]  idx;
    bit          done;
    bit          er;
    bit          ec;
  } vec_t;

  vec_t tbl[14];

  task automatic run_row(input logic [7:0] sel, input logic [23:0] data,
                         input int n, input bit st_each, output obs_t o);
    last_cnt_bad = (n != 24);
    do_row(sel, data, n, st_each, o);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t o;
    m_reset();

    tbl[0] = '{8'h04, 24'h00A5F3, 24, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    for (int r = 0; r < 8; r++)
      tbl[1+r] = '{8'(1 << r), 24'(32'h010203 * r), 24, 1'(r % 2),
                   1'b1, 3'(r), (r == 7), 1'b0, 1'b0};
    tbl[9]  = '{8'h01, 24'h7FFFFF, 23, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{8'h02, 24'h5A5A5A, 24, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{8'h00, 24'h123456, 24, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{8'h03, 24'h654321, 24, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{8'h80, 24'hC0FFEE, 24, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1};

    hold(3);
    chk("rst_frame", frame, '0);
    chk("rst_row_we", row_we, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_row_data", row_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_row", err_row, 0);
    reset = 1'b1;
    hold(6);

    for (int i = 0; i < 14; i++) begin
      run_row(tbl[i].sel, tbl[i].data, tbl[i].n, tbl[i].st_each, o);
      chk($sformatf("tbl%0d_we", i), o.we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_idx", i), o.idx, tbl[i].idx);
        chk($sformatf("tbl%0d_data", i), o.data, tbl[i].data);
      end
      chk($sformatf("tbl%0d_done", i), o.done, tbl[i].done);
      chk($sformatf("tbl%0d_err_row", i), err_row, tbl[i].er);
      chk($sformatf("tbl%0d_err_count", i), err_count, tbl[i].ec);
    end

    for (int i = 0; i < 20; i++) begin
      int          r   = $urandom_range(0, 7);
      logic [7:0]  sel = 8'(1 << r);
      int          n   = 24;
      if ($urandom_range(0, 5) == 0) sel = 8'($urandom);
      if ($urandom_range(0, 3) == 0) n = $urandom_range(20, 27);
      run_row(sel, 24'($urandom), n, 1'($urandom), o);
    end

    link_clear();
    for (int i = 0; i < 10; i++) shift_bit(1'($urandom));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_frame", frame, '0);
    chk("midrst_row_we", row_we, 0);
    chk("midrst_row_idx", row_idx, 0);
    chk("midrst_row_data", row_data, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_err_row", err_row, 0);
    hold(3);
    reset = 1'b1;
    m_reset();
    hold(6);
    run_row(8'h20, 24'h3C96E1, 24, 1'b0, o);
    chk("post_rst_we", o.we, 1);
    chk("post_rst_data", o.data, 24'h3C96E1);
    chk("post_rst_frame", frame, {72'h0, 24'h3C96E1, 96'h0, 24'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
